tdm_demultiplexer: RTL and testbench
====================================

// Module: tdm_demultiplexer
// PURPOSE
//  Receive end of the 4-slot time-division link whose transmit side is the 4:1 multiplexer.
//  Accepts one WIDTH-bit word per valid cycle, frame-aligned by frame_sync.
//  Steers each word to one of four slot registers and publishes all four together once per frame.
//  Reports framing errors and counts them.
// PARAMETERS
//  WIDTH      1   bits per slot word
//  ERR_BITS   8   width of saturating error counter
// PORTS
//  clk         in   1         rising-edge clock, single clock domain
//  reset_n     in   1         asynchronous, active-low reset
//  din         in   WIDTH     slot word from link
//  din_valid   in   1         din qualifies this cycle; no backpressure
//  frame_sync  in   1         marks din as slot 0; ignored when din_valid=0
//  out0..out3  out  WIDTH     published slot 0..3 words (slot n = address n)
//  out_valid   out  1         1-cycle pulse: out0..out3 just updated
//  address     out  2         slot index expected for the next accepted word
//  locked      out  1         1 in LOCKED state
//  sync_error  out  1         1-cycle pulse on framing error
//  err_count   out  ERR_BITS  saturating framing-error count
// BEHAVIOUR
//  Reset (async, reset_n=0): out0..3=0, out_valid=0, address=0, locked=0, sync_error=0,
//    err_count=0, shadow slots 0..2=0, state=HUNT. All outputs registered.
//  Cycles without din_valid: no state change; out_valid/sync_error deassert.
//  HUNT:
//    - din_valid & frame_sync: store din to shadow0, address<=1, go LOCKED.
//    - din_valid & !frame_sync: word discarded, stay HUNT. No error.
//  LOCKED, accepted word (din_valid=1):
//    - address=0 & frame_sync: shadow0<=din, address<=1.
//    - address=0 & !frame_sync: sync_error pulse, err_count+1, discard word,
//      address<=0, go HUNT.
//    - address=1,2 & !frame_sync: shadowN<=din, address+1.
//    - address=3 & !frame_sync: same edge: out0..2<=shadow0..2, out3<=din,
//      out_valid<=1 for one cycle, address<=0 (wrap). Stay LOCKED.
//    - address!=0 & frame_sync (early sync): sync_error pulse, err_count+1,
//      partial frame dropped (outputs untouched), din taken as slot 0:
//      shadow0<=din, address<=1, stay LOCKED.
//  Latency: out_valid and new out0..3 visible the cycle after slot-3 edge.
//  Outputs hold last published frame until next complete frame; a frame is
//    published only if all 4 slots arrived in order since a frame_sync.
//  err_count saturates at 2^ERR_BITS-1; never wraps.
//  Shadow registers are not cleared on error; always overwritten before use.
//  Reset mid-frame: partial frame lost; out0..3 forced to 0 immediately.
//  locked mirrors state (1 in LOCKED); address=0 whenever in HUNT.
// TESTING
//  1 Reset, then sync+din 1,0,1,1 on 4 consecutive valid cycles (WIDTH=1)
//    -> out0..3=1,0,1,1, out_valid one pulse, address back to 0, locked=1.
//  2 Words with gaps (din_valid low 3 cycles between slots) -> same result
//    as scenario 1; address holds during gaps; no spurious out_valid.
//  3 In HUNT, 5 valid words without frame_sync -> no out_valid, locked=0,
//    err_count=0; then sync frame 0,1,0,1 -> outputs 0,1,0,1.
//  4 After good frame, send slots 0,1 then frame_sync at address 2 -> sync_error
//    pulse, err_count=1, outputs keep prior frame; next 3 words complete new frame.
//  5 Locked, word at address 0 without frame_sync -> sync_error, err_count+1,
//    locked=0; ERR_BITS=2 with 5 errors -> err_count stays 3.
//  6 Assert reset_n=0 mid-frame between clock edges -> all outputs 0 at once,
//    locked=0; after release, behaviour identical to scenario 1.

Source files
------------

// File: rtl/tdm_demultiplexer.sv
// Receive side of the 4-slot TDM link: steers frame-aligned words into slot
// registers, publishes a complete frame at once, and tracks framing errors.
//
// state  | meaning
// HUNT   | searching for frame_sync; non-sync words are discarded silently
// LOCKED | aligned to frame; address names the slot of the next accepted word
module tdm_demultiplexer #(
   parameter int WIDTH    = 1,
   parameter int ERR_BITS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [WIDTH-1:0]    din,
   input  logic                din_valid,
   input  logic                frame_sync,
   output logic [WIDTH-1:0]    out0,
   output logic [WIDTH-1:0]    out1,
   output logic [WIDTH-1:0]    out2,
   output logic [WIDTH-1:0]    out3,
   output logic                out_valid,
   output logic [1:0]          address,
   output logic                locked,
   output logic                sync_error,
   output logic [ERR_BITS-1:0] err_count
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [ERR_BITS-1:0] ERR_MAX = '1;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    shadow0, shadow1, shadow2;
   logic [WIDTH-1:0]    shadow0_nxt, shadow1_nxt, shadow2_nxt;
   logic [WIDTH-1:0]    out0_nxt, out1_nxt, out2_nxt, out3_nxt;
   logic                out_valid_nxt;
   logic                sync_error_nxt;
   logic [1:0]          address_nxt;
   logic [ERR_BITS-1:0] err_count_nxt;
   logic                err_hit;

   // locked is a direct decode of the one-bit state flop, so it stays glitch-free
   assign locked = (state == LOCKED);

   // State, slot, publish and error registers; reset clears everything at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= HUNT;
         address    <= 2'd0;
         shadow0    <= '0;
         shadow1    <= '0;
         shadow2    <= '0;
         out0       <= '0;
         out1       <= '0;
         out2       <= '0;
         out3       <= '0;
         out_valid  <= 1'b0;
         sync_error <= 1'b0;
         err_count  <= '0;
      end else begin
         state      <= state_nxt;
         address    <= address_nxt;
         shadow0    <= shadow0_nxt;
         shadow1    <= shadow1_nxt;
         shadow2    <= shadow2_nxt;
         out0       <= out0_nxt;
         out1       <= out1_nxt;
         out2       <= out2_nxt;
         out3       <= out3_nxt;
         out_valid  <= out_valid_nxt;
         sync_error <= sync_error_nxt;
         err_count  <= err_count_nxt;
      end
   end

   // Next-state decode: only accepted words move the FSM; pulses default low
   always_comb begin
      state_nxt      = state;
      address_nxt    = address;
      shadow0_nxt    = shadow0;
      shadow1_nxt    = shadow1;
      shadow2_nxt    = shadow2;
      out0_nxt       = out0;
      out1_nxt       = out1;
      out2_nxt       = out2;
      out3_nxt       = out3;
      out_valid_nxt  = 1'b0;
      sync_error_nxt = 1'b0;
      err_count_nxt  = err_count;
      err_hit        = 1'b0;

      if (din_valid) begin
         unique case (state)
            HUNT: begin
               if (frame_sync) begin
                  shadow0_nxt = din;
                  address_nxt = 2'd1;
                  state_nxt   = LOCKED;
               end
            end
            LOCKED: begin
               if (frame_sync) begin
                  // early sync drops the partial frame and restarts at slot 0
                  err_hit     = (address != 2'd0);
                  shadow0_nxt = din;
                  address_nxt = 2'd1;
               end else begin
                  unique case (address)
                     2'd0: begin
                        err_hit     = 1'b1;
                        address_nxt = 2'd0;
                        state_nxt   = HUNT;
                     end
                     2'd1: begin
                        shadow1_nxt = din;
                        address_nxt = 2'd2;
                     end
                     2'd2: begin
                        shadow2_nxt = din;
                        address_nxt = 2'd3;
                     end
                     2'd3: begin
                        out0_nxt      = shadow0;
                        out1_nxt      = shadow1;
                        out2_nxt      = shadow2;
                        out3_nxt      = din;
                        out_valid_nxt = 1'b1;
                        address_nxt   = 2'd0;
                     end
                     default: ;
                  endcase
               end
            end
            default: begin
               state_nxt   = HUNT;
               address_nxt = 2'd0;
            end
         endcase
      end

      if (err_hit) begin
         sync_error_nxt = 1'b1;
         if (err_count != ERR_MAX)
            err_count_nxt = err_count + ERR_BITS'(1);
      end
   end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Directed bench for the TDM demultiplexer; 2-bit error counter to reach saturation.
module tb_tdm_demultiplexer;

   localparam int WIDTH    = 1;
   localparam int ERR_BITS = 2;

   logic                clk;
   logic                reset_n;
   logic [WIDTH-1:0]    din;
   logic                din_valid;
   logic                frame_sync;
   logic [WIDTH-1:0]    out0, out1, out2, out3;
   logic                out_valid;
   logic [1:0]          address;
   logic                locked;
   logic                sync_error;
   logic [ERR_BITS-1:0] err_count;
   logic [3:0]          outs;

   int n_checks = 0;
   int n_errors = 0;

   tdm_demultiplexer #(.WIDTH(WIDTH), .ERR_BITS(ERR_BITS)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .out0       (out0),
      .out1       (out1),
      .out2       (out2),
      .out3       (out3),
      .out_valid  (out_valid),
      .address    (address),
      .locked     (locked),
      .sync_error (sync_error),
      .err_count  (err_count)
   );

   assign outs = {out3, out2, out1, out0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called at a negedge; returns at the next negedge with the edge's results visible
   task automatic step(input logic v, input logic fs, input logic d);
      din_valid  = v;
      frame_sync = fs;
      din        = d;
      @(posedge clk);
      @(negedge clk);
      din_valid  = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   // w[n] is the slot-n word; gap idle cycles follow each slot
   task automatic send_frame(input string tag, input logic [3:0] w, input int gap);
      logic [3:0] prev;
      prev = outs;
      for (int n = 0; n < 4; n++) begin
         step(1'b1, n == 0, w[n]);
         if (n < 3) begin
            check({tag, " addr"}, address, n + 1);
            check({tag, " no_valid"}, out_valid, 0);
            check({tag, " held_outs"}, outs, prev);
         end else begin
            check({tag, " valid"}, out_valid, 1);
            check({tag, " outs"}, outs, w);
            check({tag, " wrap"}, address, 0);
         end
         check({tag, " locked"}, locked, 1);
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'b0, 1'b0);
            check({tag, " gap_addr"}, address, (n + 1) % 4);
            check({tag, " gap_valid"}, out_valid, 0);
         end
      end
   endtask

   task automatic pulse_reset;
      reset_n = 1'b0;
      #3;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset_n    = 1'b0;
      din        = '0;
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      #12;
      check("rst outs", outs, 0);
      check("rst valid", out_valid, 0);
      check("rst addr", address, 0);
      check("rst locked", locked, 0);
      check("rst serr", sync_error, 0);
      check("rst errcnt", err_count, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // scenario 1: back-to-back frame 1,0,1,1
      send_frame("s1", 4'b1101, 0);
      step(1'b0, 1'b0, 1'b0);
      check("s1 pulse_end", out_valid, 0);
      check("s1 hold", outs, 4'b1101);

      // scenario 2: same frame with 3 idle cycles between slots
      send_frame("s2", 4'b1101, 3);
      check("s2 errcnt", err_count, 0);

      // scenario 3: hunting ignores non-sync words
      pulse_reset();
      check("s3 rst_outs", outs, 0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, i[0]);
         check("s3 no_valid", out_valid, 0);
         check("s3 unlocked", locked, 0);
         check("s3 addr", address, 0);
         check("s3 errcnt", err_count, 0);
         check("s3 serr", sync_error, 0);
      end
      send_frame("s3", 4'b1010, 0);

      // scenario 4: early sync at address 2
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      check("s4 addr2", address, 2);
      step(1'b1, 1'b1, 1'b0);
      check("s4 serr", sync_error, 1);
      check("s4 errcnt", err_count, 1);
      check("s4 outs_kept", outs, 4'b1010);
      check("s4 no_valid", out_valid, 0);
      check("s4 addr1", address, 1);
      check("s4 locked", locked, 1);
      step(1'b1, 1'b0, 1'b1);
      check("s4 serr_end", sync_error, 0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      check("s4 valid", out_valid, 1);
      check("s4 outs_new", outs, 4'b0110);

      // scenario 5: missing sync at address 0, counter saturates at 3
      step(1'b1, 1'b0, 1'b1);
      check("s5 serr", sync_error, 1);
      check("s5 errcnt", err_count, 2);
      check("s5 unlocked", locked, 0);
      check("s5 addr", address, 0);
      check("s5 outs_kept", outs, 4'b0110);
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 1'b1, 1'b1);
         step(1'b1, 1'b0, 1'b1);
         step(1'b1, 1'b0, 1'b1);
         step(1'b1, 1'b0, 1'b1);
         check("s5 loop_valid", out_valid, 1);
         step(1'b1, 1'b0, 1'b0);
         check("s5 loop_serr", sync_error, 1);
         check("s5 loop_errcnt", err_count, (2 + i > 3) ? 3 : 2 + i);
         check("s5 loop_unlocked", locked, 0);
      end
      check("s5 outs", outs, 4'b1111);

      // scenario 6: asynchronous reset mid-frame
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check("s6 addr_pre", address, 2);
      #2;
      reset_n = 1'b0;
      #1;
      check("s6 outs", outs, 0);
      check("s6 locked", locked, 0);
      check("s6 addr", address, 0);
      check("s6 errcnt", err_count, 0);
      check("s6 valid", out_valid, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      send_frame("s6", 4'b1101, 0);
      step(1'b0, 1'b0, 1'b0);
      check("s6 pulse_end", out_valid, 0);
      check("s6 errcnt_end", err_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
